// File: rtl/pbru_out_dis.sv
// Output distributor: buffers wide core words in a FIFO and serializes each into SET_NUMBER narrow lanes, LSB lane first.
// Optional o_ex_last marker on the final lane of a word is enabled by defining PBRU_OUT_DIS_LAST_EN.
module pbru_out_dis #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int SET_NUMBER   = 64,
  parameter int INPUT_WIDTH  = OUTPUT_WIDTH * SET_NUMBER,
  parameter int RAM_DEPTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_co_wr_valid,
  input  logic [INPUT_WIDTH-1:0]  i_co_data,
  output logic                    o_co_full,
  input  logic                    i_ex_rd_ready,
  output logic                    o_ex_data_valid,
  output logic [OUTPUT_WIDTH-1:0] o_ex_data,
`ifdef PBRU_OUT_DIS_LAST_EN
  output logic                    o_ex_last,
`endif
  output logic                    o_ex_empty
);

  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);
  localparam int LANE_WIDTH = $clog2(SET_NUMBER);
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(SET_NUMBER - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q;
  logic [INPUT_WIDTH-1:0]  mem_q [RAM_DEPTH];
  logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
  logic [INPUT_WIDTH-1:0]  word_q;
  logic [LANE_WIDTH-1:0]   lane_cnt_q;
  logic [INPUT_WIDTH-1:0]  rd_word;
  logic                    fifo_empty;
  logic                    wr_en;
  logic                    xfer;
  logic                    lane_last;
  logic                    pop;

  assign fifo_empty = (rd_ptr_q == wr_ptr_q);
  assign o_co_full  = (rd_ptr_q == {~wr_ptr_q[ADDR_WIDTH], wr_ptr_q[ADDR_WIDTH-1:0]});
  assign wr_en      = i_co_wr_valid && !o_co_full;
  assign rd_word    = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  assign o_ex_data_valid = (state_q == SEND);
  // The word register shifts down one lane per transfer, so lane 0 always sits at the bottom.
  assign o_ex_data  = word_q[OUTPUT_WIDTH-1:0];
  assign lane_last  = (lane_cnt_q == LAST_LANE);
  assign xfer       = o_ex_data_valid && i_ex_rd_ready;
  assign pop        = !fifo_empty && ((state_q == IDLE) || (xfer && lane_last));
  assign o_ex_empty = fifo_empty && (state_q == IDLE);

`ifdef PBRU_OUT_DIS_LAST_EN
  assign o_ex_last  = o_ex_data_valid && lane_last;
`endif

  assign wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(wr_en);
  assign rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(pop);

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_co_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      word_q     <= '0;
      lane_cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            word_q     <= rd_word;
            lane_cnt_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (!lane_last) begin
              word_q     <= word_q >> OUTPUT_WIDTH;
              lane_cnt_q <= lane_cnt_q + 1'b1;
            end else if (pop) begin
              word_q     <= rd_word;
              lane_cnt_q <= '0;
            end else begin
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbru_out_dis.sv
// Directed bench for pbru_out_dis with SET_NUMBER=4, OUTPUT_WIDTH=16, RAM_DEPTH=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_pbru_out_dis;

  localparam int OW = 16;
  localparam int SN = 4;
  localparam int IW = OW * SN;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_co_wr_valid;
  logic [IW-1:0] i_co_data;
  logic          o_co_full;
  logic          i_ex_rd_ready;
  logic          o_ex_data_valid;
  logic [OW-1:0] o_ex_data;
  logic          o_ex_empty;
`ifdef PBRU_OUT_DIS_LAST_EN
  logic          o_ex_last;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  pbru_out_dis #(
    .OUTPUT_WIDTH(OW),
    .SET_NUMBER  (SN),
    .INPUT_WIDTH (IW),
    .RAM_DEPTH   (RD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_co_wr_valid  (i_co_wr_valid),
    .i_co_data      (i_co_data),
    .o_co_full      (o_co_full),
    .i_ex_rd_ready  (i_ex_rd_ready),
    .o_ex_data_valid(o_ex_data_valid),
    .o_ex_data      (o_ex_data),
`ifdef PBRU_OUT_DIS_LAST_EN
    .o_ex_last      (o_ex_last),
`endif
    .o_ex_empty     (o_ex_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk_word(input logic [OW-1:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  // Drives one write for exactly one rising edge; back-to-back calls give continuous writes.
  task automatic write_word(input logic [IW-1:0] w);
    i_co_wr_valid = 1'b1;
    i_co_data     = w;
    @(negedge clk);
    i_co_wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_co_wr_valid = 1'b0;
    i_co_data = '0;
    i_ex_rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (o_ex_data_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_ex_data_valid); else pass_cnt++;
    total_cnt++; if (o_ex_data !== 16'h0000) $display("FAIL reset_data got=%h exp=0000", o_ex_data); else pass_cnt++;
    total_cnt++; if (o_co_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", o_co_full); else pass_cnt++;
    total_cnt++; if (o_ex_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", o_ex_empty); else pass_cnt++;
`ifdef PBRU_OUT_DIS_LAST_EN
    total_cnt++; if (o_ex_last !== 1'b0) $display("FAIL reset_last got=%b exp=0", o_ex_last); else pass_cnt++;
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    i_ex_rd_ready = 1'b1;
    write_word(64'h0004_0003_0002_0001);
    // One edge after the write edge the word is only just being loaded.
    total_cnt++; if (o_ex_data_valid !== 1'b0) $display("FAIL basic_latency_valid got=%b exp=0", o_ex_data_valid); else pass_cnt++;
    total_cnt++; if (o_ex_empty !== 1'b0) $display("FAIL basic_not_empty got=%b exp=0", o_ex_empty); else pass_cnt++;
    @(negedge clk);
    for (int k = 0; k < SN; k++) begin
      total_cnt++; if (o_ex_data_valid !== 1'b1) $display("FAIL basic_valid lane=%0d got=%b exp=1", k, o_ex_data_valid); else pass_cnt++;
      total_cnt++; if (o_ex_data !== OW'(k + 1)) $display("FAIL basic_data lane=%0d got=%h exp=%h", k, o_ex_data, OW'(k + 1)); else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (o_ex_data_valid !== 1'b0) $display("FAIL basic_end_valid got=%b exp=0", o_ex_data_valid); else pass_cnt++;
    total_cnt++; if (o_ex_empty !== 1'b1) $display("FAIL basic_end_empty got=%b exp=1", o_ex_empty); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    i_ex_rd_ready = 1'b1;
    write_word(64'h0004_0003_0002_0001);
    @(negedge clk);
    total_cnt++; if (o_ex_data !== 16'h0001) $display("FAIL bp_lane1 got=%h exp=0001", o_ex_data); else pass_cnt++;
    @(negedge clk);
    i_ex_rd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total_cnt++; if (o_ex_data !== 16'h0002) $display("FAIL bp_hold_data cyc=%0d got=%h exp=0002", c, o_ex_data); else pass_cnt++;
      total_cnt++; if (o_ex_data_valid !== 1'b1) $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, o_ex_data_valid); else pass_cnt++;
      @(negedge clk);
    end
    i_ex_rd_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      total_cnt++; if (o_ex_data !== OW'(k)) $display("FAIL bp_resume lane=%0d got=%h exp=%h", k, o_ex_data, OW'(k)); else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (o_ex_data_valid !== 1'b0) $display("FAIL bp_end_valid got=%b exp=0", o_ex_data_valid); else pass_cnt++;
  endtask

  // Word A moves into the serializer right away, so B..E fill the 4-deep FIFO and F is dropped.
  task automatic test_full();
    logic [OW-1:0] bases [6];
    bases[0] = 16'hA000; bases[1] = 16'hB000; bases[2] = 16'hC000;
    bases[3] = 16'hD000; bases[4] = 16'hE000; bases[5] = 16'hF000;
    i_ex_rd_ready = 1'b0;
    for (int w = 0; w < 5; w++) begin
      write_word(mk_word(bases[w]));
      if (w == 3) begin
        total_cnt++; if (o_co_full !== 1'b0) $display("FAIL full_after4 got=%b exp=0", o_co_full); else pass_cnt++;
      end
    end
    total_cnt++; if (o_co_full !== 1'b1) $display("FAIL full_after5 got=%b exp=1", o_co_full); else pass_cnt++;
    write_word(mk_word(bases[5]));
    total_cnt++; if (o_co_full !== 1'b1) $display("FAIL full_after_drop got=%b exp=1", o_co_full); else pass_cnt++;
    i_ex_rd_ready = 1'b1;
    for (int i = 0; i < 5 * SN; i++) begin
      total_cnt++;
      if (o_ex_data_valid !== 1'b1 || o_ex_data !== bases[i / SN] + OW'(i % SN))
        $display("FAIL full_drain idx=%0d got=%b/%h exp=1/%h", i, o_ex_data_valid, o_ex_data, bases[i / SN] + OW'(i % SN));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (o_ex_data_valid !== 1'b0) $display("FAIL full_no_extra got=%b exp=0", o_ex_data_valid); else pass_cnt++;
    total_cnt++; if (o_ex_empty !== 1'b1) $display("FAIL full_end_empty got=%b exp=1", o_ex_empty); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] exp_lane;
    i_ex_rd_ready = 1'b0;
    write_word(mk_word(16'h1100));
    write_word(mk_word(16'h2200));
    @(negedge clk);
    i_ex_rd_ready = 1'b1;
    for (int i = 0; i < 2 * SN; i++) begin
      exp_lane = (i < SN) ? 16'h1100 + OW'(i) : 16'h2200 + OW'(i - SN);
      total_cnt++;
      if (o_ex_data_valid !== 1'b1 || o_ex_data !== exp_lane)
        $display("FAIL b2b idx=%0d got=%b/%h exp=1/%h", i, o_ex_data_valid, o_ex_data, exp_lane);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (o_ex_data_valid !== 1'b0) $display("FAIL b2b_end_valid got=%b exp=0", o_ex_data_valid); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    i_ex_rd_ready = 1'b0;
    write_word(mk_word(16'h3300));
    write_word(mk_word(16'h4400));
    i_ex_rd_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (o_ex_data !== 16'h3301) $display("FAIL mid_lane2 got=%h exp=3301", o_ex_data); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (o_ex_data_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", o_ex_data_valid); else pass_cnt++;
    total_cnt++; if (o_ex_empty !== 1'b1) $display("FAIL mid_rst_empty got=%b exp=1", o_ex_empty); else pass_cnt++;
    total_cnt++; if (o_co_full !== 1'b0) $display("FAIL mid_rst_full got=%b exp=0", o_co_full); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    write_word(mk_word(16'h5500));
    @(negedge clk);
    for (int k = 0; k < SN; k++) begin
      total_cnt++;
      if (o_ex_data_valid !== 1'b1 || o_ex_data !== 16'h5500 + OW'(k))
        $display("FAIL mid_new lane=%0d got=%b/%h exp=1/%h", k, o_ex_data_valid, o_ex_data, 16'h5500 + OW'(k));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (o_ex_data_valid !== 1'b0) $display("FAIL mid_no_stale got=%b exp=0", o_ex_data_valid); else pass_cnt++;
    total_cnt++; if (o_ex_empty !== 1'b1) $display("FAIL mid_end_empty got=%b exp=1", o_ex_empty); else pass_cnt++;
  endtask

`ifdef PBRU_OUT_DIS_LAST_EN
  task automatic test_last();
    i_ex_rd_ready = 1'b1;
    write_word(64'h0004_0003_0002_0001);
    @(negedge clk);
    for (int k = 0; k < SN; k++) begin
      total_cnt++; if (o_ex_last !== (k == SN - 1)) $display("FAIL last_flag lane=%0d got=%b exp=%b", k, o_ex_last, (k == SN - 1)); else pass_cnt++;
      if (k < SN - 1) @(negedge clk);
    end
    i_ex_rd_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total_cnt++; if (o_ex_last !== 1'b1 || o_ex_data !== 16'h0004) $display("FAIL last_hold cyc=%0d got=%b/%h exp=1/0004", c, o_ex_last, o_ex_data); else pass_cnt++;
    end
    i_ex_rd_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (o_ex_last !== 1'b0 || o_ex_data_valid !== 1'b0) $display("FAIL last_end got=%b/%b exp=0/0", o_ex_last, o_ex_data_valid); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full();
    test_back_to_back();
    test_reset_midop();
`ifdef PBRU_OUT_DIS_LAST_EN
    test_last();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
